// File: rtl/pqpq_if.sv
// Command/result bundle for the pqpq arithmetic unit.
// The master drives the opcode, operand and read select; the slave returns results.
interface pqpq_if;
  logic [1:0]  x;
  logic [34:0] y;
  logic [1:0]  rd_sel;
  logic [31:0] rd_data;
  logic [31:0] res;
  logic        res_valid;
  logic        ovf;
  logic        ovf_sticky;

  modport master (
    output x, y, rd_sel,
    input  rd_data, res, res_valid, ovf, ovf_sticky
  );

  modport slave (
    input  x, y, rd_sel,
    output rd_data, res, res_valid, ovf, ovf_sticky
  );
endinterface

// File: rtl/pqpq.sv
// Four-register accumulator: LOAD/ADD/SUB with optional saturation against QWE.
// Results are registered; the register file is also readable combinationally.
module pqpq #(
  parameter logic [31:0] QWE = 32'hFFFF_FFFF
) (
  input logic   clk,
  input logic   reset,
  pqpq_if.slave bus
);
  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_LOAD = 2'b01,
    OP_ADD  = 2'b10,
    OP_SUB  = 2'b11
  } op_t;

  logic [31:0] regs [4];
  logic [31:0] res_q;
  logic        valid_q;
  logic        ovf_q;
  logic        sticky_q;

  op_t         op;
  logic [1:0]  s;
  logic        sat;
  logic [31:0] v;
  logic [31:0] cur;
  logic [32:0] sum;
  logic [31:0] diff;
  logic        borrow;
  logic [31:0] nxt;
  logic        ovf_n;

  assign op  = op_t'(bus.x);
  assign s   = bus.y[34:33];
  assign sat = bus.y[32];
  assign v   = bus.y[31:0];
  assign cur = regs[s];

  always_comb begin
    sum    = {1'b0, cur} + {1'b0, v};
    diff   = cur - v;
    borrow = (v > cur);
    nxt    = cur;
    ovf_n  = 1'b0;
    unique case (op)
      OP_LOAD: begin
        if (sat && (v > QWE)) begin
          nxt   = QWE;
          ovf_n = 1'b1;
        end else begin
          nxt = v;
        end
      end
      OP_ADD: begin
        if (!sat) begin
          nxt   = sum[31:0];
          ovf_n = sum[32];
        end else if (sum > {1'b0, QWE}) begin
          nxt   = QWE;
          ovf_n = 1'b1;
        end else begin
          nxt = sum[31:0];
        end
      end
      OP_SUB: begin
        if (!sat) begin
          nxt   = diff;
          ovf_n = borrow;
        end else if (borrow) begin
          nxt   = '0;
          ovf_n = 1'b1;
        end else if (diff > QWE) begin
          nxt   = QWE;
          ovf_n = 1'b1;
        end else begin
          nxt = diff;
        end
      end
      default: begin
        nxt   = cur;
        ovf_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 4; i++) regs[i] <= '0;
      res_q    <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else if (op != OP_NOP) begin
      regs[s]  <= nxt;
      res_q    <= nxt;
      valid_q  <= 1'b1;
      ovf_q    <= ovf_n;
      sticky_q <= sticky_q | ovf_n;
    end else begin
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end
  end

  assign bus.rd_data    = regs[bus.rd_sel];
  assign bus.res        = res_q;
  assign bus.res_valid  = valid_q;
  assign bus.ovf        = ovf_q;
  assign bus.ovf_sticky = sticky_q;
endmodule

// File: tb/tb_pqpq.sv
// Bench for pqpq: two instances (default ceiling and ceiling 100) driven identically
// and compared every cycle against an arithmetic reference model.
module tb_pqpq;
  localparam longint unsigned TWO32 = 64'h1_0000_0000;
  localparam longint unsigned QA = 64'hFFFF_FFFF;
  localparam longint unsigned QB = 64'd100;

  logic        clk = 1'b0;
  logic        d_rst = 1'b0;
  logic [1:0]  d_x = 2'b00;
  logic [1:0]  d_s = 2'b00;
  logic        d_sat = 1'b0;
  logic [31:0] d_v = '0;
  logic [1:0]  d_rdsel = 2'b00;

  int n_chk = 0;
  int n_fail = 0;
  bit started = 0;

  longint unsigned mr [2][4];
  longint unsigned m_res [2];
  bit              m_valid [2];
  bit              m_ovf [2];
  bit              m_sticky [2];

  pqpq_if bus0 ();
  pqpq_if bus1 ();

  assign bus0.x = d_x;
  assign bus0.y = {d_s, d_sat, d_v};
  assign bus0.rd_sel = d_rdsel;
  assign bus1.x = d_x;
  assign bus1.y = {d_s, d_sat, d_v};
  assign bus1.rd_sel = d_rdsel;

  pqpq dut_a (.clk(clk), .reset(d_rst), .bus(bus0));
  pqpq #(.QWE(32'd100)) dut_b (.clk(clk), .reset(d_rst), .bus(bus1));

  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: outcome of one command applied to a register value, ceiling q.
  task automatic model_apply(input int k, input longint unsigned q);
    longint unsigned r, vv, t;
    bit o;
    r = mr[k][d_s];
    vv = longint'(d_v);
    o = 0;
    case (d_x)
      2'b01: begin
        if (d_sat && vv > q) begin r = q; o = 1; end
        else r = vv;
      end
      2'b10: begin
        t = r + vv;
        if (d_sat) begin
          if (t > q) begin r = q; o = 1; end
          else r = t;
        end else begin
          o = (t >= TWO32);
          r = t % TWO32;
        end
      end
      default: begin
        if (vv > r) begin
          o = 1;
          r = d_sat ? 0 : (r + TWO32 - vv);
        end else begin
          r = r - vv;
          if (d_sat && r > q) begin r = q; o = 1; end
        end
      end
    endcase
    mr[k][d_s] = r;
    m_res[k] = r;
    m_valid[k] = 1;
    m_ovf[k] = o;
    if (o) m_sticky[k] = 1;
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (!d_rst) begin
        for (int i = 0; i < 4; i++) mr[k][i] = 0;
        m_res[k] = 0; m_valid[k] = 0; m_ovf[k] = 0; m_sticky[k] = 0;
      end else if (d_x == 2'b00) begin
        m_valid[k] = 0; m_ovf[k] = 0;
      end else begin
        model_apply(k, (k == 0) ? QA : QB);
      end
    end
  endtask

  // Present a command, let one rising edge consume it, advance the model.
  task automatic cmd(input bit rst, input logic [1:0] op, input logic [1:0] s,
                     input bit sat, input logic [31:0] v);
    d_rst = rst; d_x = op; d_s = s; d_sat = sat; d_v = v;
    d_rdsel = 2'($urandom_range(0, 3));
    @(posedge clk);
    model_step();
    started = 1;
    #1;
  endtask

  task automatic rd(input int k, input logic [1:0] sel, input logic [31:0] exp, input string name);
    d_rdsel = sel;
    #1;
    chk(name, (k == 0) ? bus0.rd_data : bus1.rd_data, exp);
  endtask

  // Every cycle away from the edge: outputs and the read port against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("a_res", bus0.res, 32'(m_res[0]));
      chk("a_valid", 32'(bus0.res_valid), 32'(m_valid[0]));
      chk("a_ovf", 32'(bus0.ovf), 32'(m_ovf[0]));
      chk("a_sticky", 32'(bus0.ovf_sticky), 32'(m_sticky[0]));
      chk("a_rd_data", bus0.rd_data, 32'(mr[0][d_rdsel]));
      chk("b_res", bus1.res, 32'(m_res[1]));
      chk("b_valid", 32'(bus1.res_valid), 32'(m_valid[1]));
      chk("b_ovf", 32'(bus1.ovf), 32'(m_ovf[1]));
      chk("b_sticky", 32'(bus1.ovf_sticky), 32'(m_sticky[1]));
      chk("b_rd_data", bus1.rd_data, 32'(mr[1][d_rdsel]));
    end
  end

  function automatic logic [31:0] pick_v(input longint unsigned q);
    case ($urandom_range(0, 5))
      0: return 32'($urandom_range(0, 15));
      1: return 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
      2: return 32'(q) - 32'($urandom_range(0, 3)) + 32'($urandom_range(0, 3));
      3: return 32'($urandom_range(0, 200));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    // reset, then LOAD R2=5
    cmd(0, 2'b00, 0, 0, 0);
    cmd(0, 2'b10, 1, 0, 32'd9);
    chk("rst_res", bus0.res, 32'd0);
    chk("rst_valid", 32'(bus0.res_valid), 32'd0);
    chk("rst_sticky", 32'(bus0.ovf_sticky), 32'd0);
    cmd(1, 2'b01, 2, 0, 32'd5);
    chk("load_res", bus0.res, 32'd5);
    chk("load_valid", 32'(bus0.res_valid), 32'd1);
    chk("load_ovf", 32'(bus0.ovf), 32'd0);
    rd(0, 2, 32'd5, "load_rd2");
    rd(0, 0, 32'd0, "load_rd0");
    rd(0, 1, 32'd0, "load_rd1");
    rd(0, 3, 32'd0, "load_rd3");
    rd(1, 2, 32'd5, "load_b_rd2");

    // wrapping ADD
    cmd(1, 2'b01, 1, 0, 32'hFFFF_FFFF);
    cmd(1, 2'b10, 1, 0, 32'd2);
    chk("wrap_res", bus0.res, 32'd1);
    chk("wrap_ovf", 32'(bus0.ovf), 32'd1);
    chk("wrap_sticky", 32'(bus0.ovf_sticky), 32'd1);
    cmd(1, 2'b00, 0, 0, 0);
    chk("wrap_ovf_pulse", 32'(bus0.ovf), 32'd0);
    chk("wrap_sticky_hold", 32'(bus0.ovf_sticky), 32'd1);
    rd(0, 1, 32'd1, "wrap_rd1");

    // saturating ADD against ceiling 100
    cmd(1, 2'b01, 0, 0, 32'd90);
    cmd(1, 2'b10, 0, 1, 32'd20);
    chk("sat_add20", bus1.res, 32'd100);
    chk("sat_add20_ovf", 32'(bus1.ovf), 32'd1);
    chk("sat_add20_dflt", bus0.res, 32'd110);
    cmd(1, 2'b10, 0, 1, 32'd10);
    chk("sat_add10", bus1.res, 32'd100);
    chk("sat_add10_ovf", 32'(bus1.ovf), 32'd1);
    cmd(1, 2'b10, 0, 1, 32'd0);
    chk("sat_add0", bus1.res, 32'd100);
    chk("sat_add0_ovf", 32'(bus1.ovf), 32'd0);

    // SUB underflow, saturating and wrapping
    cmd(1, 2'b01, 3, 0, 32'd3);
    cmd(1, 2'b11, 3, 1, 32'd5);
    chk("sub_sat_res", bus0.res, 32'd0);
    chk("sub_sat_ovf", 32'(bus0.ovf), 32'd1);
    cmd(1, 2'b01, 3, 0, 32'd3);
    cmd(1, 2'b11, 3, 0, 32'd5);
    chk("sub_wrap_res", bus0.res, 32'hFFFF_FFFE);
    chk("sub_wrap_ovf", 32'(bus0.ovf), 32'd1);
    rd(0, 3, 32'hFFFF_FFFE, "sub_wrap_rd3");

    // back-to-back chaining then NOP
    cmd(1, 2'b01, 0, 0, 32'd7);
    chk("chain0", bus0.res, 32'd7);
    cmd(1, 2'b10, 0, 0, 32'd1);
    chk("chain1", bus0.res, 32'd8);
    chk("chain1_valid", 32'(bus0.res_valid), 32'd1);
    cmd(1, 2'b10, 0, 0, 32'd1);
    chk("chain2", bus0.res, 32'd9);
    chk("chain2_valid", 32'(bus0.res_valid), 32'd1);
    cmd(1, 2'b00, 0, 0, 32'd1);
    chk("nop_valid", 32'(bus0.res_valid), 32'd0);
    chk("nop_res", bus0.res, 32'd9);

    // reset beats a simultaneous command
    cmd(1, 2'b01, 2, 0, 32'd10);
    cmd(0, 2'b10, 2, 0, 32'd1);
    rd(0, 2, 32'd0, "midrst_rd2");
    chk("midrst_res", bus0.res, 32'd0);
    chk("midrst_valid", 32'(bus0.res_valid), 32'd0);
    chk("midrst_sticky", 32'(bus0.ovf_sticky), 32'd0);

    // randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      logic [1:0] op_r, s_r;
      logic [31:0] v_r;
      op_r = 2'($urandom_range(0, 3));
      s_r = 2'($urandom_range(0, 3));
      v_r = pick_v(($urandom_range(0, 1) == 0) ? QA : QB);
      cmd(($urandom_range(0, 59) != 0), op_r, s_r, 1'($urandom_range(0, 1)), v_r);
    end

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
